// File: rtl/cpu_pkg.sv
// Shared constants, state encoding and decode bundle for the 8-bit mini CPU.
package cpu_pkg;

    localparam logic [1:0] OP_LI   = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_SW   = 2'b11;

    localparam logic [1:0] WB_IMM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_ADDI = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_PAUSE     = 3'd6
    } ctrl_state_t;

    typedef struct packed {
        logic       reg_we;
        logic       mem_we;
        logic [1:0] wb_sel;
    } ctrl_dec_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Opcode to control-bundle decoder; outputs are ungated and the
// sequencer qualifies them by phase.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [1:0] opcode,
    output ctrl_dec_t  dec
);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (opcode == OP_LI): begin
                dec.reg_we = 1'b1;
                dec.wb_sel = WB_IMM;
            end
            (opcode == OP_ADD): begin
                dec.reg_we = 1'b1;
                dec.wb_sel = WB_ALU;
            end
            (opcode == OP_ADDI): begin
                dec.reg_we = 1'b1;
                dec.wb_sel = WB_ADDI;
            end
            (opcode == OP_SW): begin
                dec.mem_we = 1'b1;
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer.
// Define CPU_CTRL_STEP_EN to add single-step ports and the PAUSE state.
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int             PC_W         = 4,
    parameter logic [PC_W-1:0] LAST_ADDR   = PC_W'(4'hF),
    parameter bit             HALT_ON_LAST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef CPU_CTRL_STEP_EN
    input  logic            step_mode,
    input  logic            step,
`endif
    input  logic [7:0]      instr,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic            reg_write_en,
    output logic [1:0]      wb_sel,
    output logic            mem_write_en,
    output logic            busy,
    output logic            halted,
    output logic [7:0]      retired
);

    ctrl_state_t state, state_d;
    ctrl_dec_t   dec;
    logic        idle_like;
    logic        hold_last;

    cpu_ctrl_decode u_dec (
        .opcode (ir[7:6]),
        .dec    (dec)
    );

    assign idle_like = (state == ST_IDLE) || (state == ST_HALT);
    assign hold_last = HALT_ON_LAST && (pc == LAST_ADDR);

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE, ST_HALT: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                if (hold_last) state_d = ST_HALT;
`ifdef CPU_CTRL_STEP_EN
                else if (step_mode) state_d = ST_PAUSE;
`endif
                else state_d = ST_FETCH;
            end
`ifdef CPU_CTRL_STEP_EN
            ST_PAUSE: begin
                if (step || !step_mode) state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            pc      <= '0;
            ir      <= 8'h00;
            retired <= 8'h00;
        end else begin
            state <= state_d;
            if (idle_like && start) begin
                pc      <= '0;
                retired <= 8'h00;
            end
            if (state == ST_FETCH) ir <= instr;
            if (state == ST_WRITEBACK) begin
                if (retired != 8'hFF) retired <= retired + 8'd1;
                if (!hold_last) pc <= pc + PC_W'(1);
            end
        end
    end

    // Strobes are masked in a reset cycle so an aborted instruction
    // never reaches the register file or memory.
    assign mem_write_en = !reset && (state == ST_EXECUTE) && dec.mem_we;
    assign reg_write_en = !reset && (state == ST_WRITEBACK) && dec.reg_we;
    assign wb_sel       = (state == ST_WRITEBACK) ? dec.wb_sel : WB_IMM;

    assign busy   = (state == ST_FETCH) || (state == ST_DECODE) ||
                    (state == ST_EXECUTE) || (state == ST_WRITEBACK) ||
                    (state == ST_PAUSE);
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: halting and wrapping instances checked against
// a cycle-count reference model, decode vectors and corner sequences.
module tb_cpu_ctrl_seq;

    typedef struct {
        logic [7:0] instr;
        logic       exp_reg;
        logic       exp_mem;
        logic [1:0] exp_wb;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
`endif
    logic [7:0] rom [16];

    logic [3:0] pc_a, pc_b;
    logic [7:0] ir_a, ir_b, ret_a, ret_b, instr_a, instr_b;
    logic       rwe_a, rwe_b, mwe_a, mwe_b;
    logic       busy_a, busy_b, halt_a, halt_b;
    logic [1:0] wb_a, wb_b;

    int n_vec = 0;
    int n_err = 0;

    // Model: run 0 idle, 1 running, 2 halted, 3 paused
    int m_run [2];
    int m_cyc [2];
    int m_pc  [2];
    int m_ir  [2];
    int m_ret [2];

    vec_t vecs [4];

    always #5 clk = ~clk;

    assign instr_a = rom[pc_a];
    assign instr_b = rom[pc_b];

    cpu_ctrl_seq #(.PC_W(4), .LAST_ADDR(4'hF), .HALT_ON_LAST(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef CPU_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .instr(instr_a), .pc(pc_a), .ir(ir_a),
        .reg_write_en(rwe_a), .wb_sel(wb_a), .mem_write_en(mwe_a),
        .busy(busy_a), .halted(halt_a), .retired(ret_a)
    );

    cpu_ctrl_seq #(.PC_W(4), .LAST_ADDR(4'hF), .HALT_ON_LAST(1'b0)) dut_w (
        .clk(clk), .reset(reset), .start(start),
`ifdef CPU_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .instr(instr_b), .pc(pc_b), .ir(ir_b),
        .reg_write_en(rwe_b), .wb_sel(wb_b), .mem_write_en(mwe_b),
        .busy(busy_b), .halted(halt_b), .retired(ret_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int i);
        int ph;
        if (reset) begin
            m_run[i] = 0; m_cyc[i] = 0; m_pc[i] = 0;
            m_ir[i] = 0; m_ret[i] = 0;
        end else if (m_run[i] == 0 || m_run[i] == 2) begin
            if (start) begin
                m_run[i] = 1; m_cyc[i] = 0; m_pc[i] = 0; m_ret[i] = 0;
            end
        end else if (m_run[i] == 1) begin
            ph = m_cyc[i] % 4;
            if (ph == 0) m_ir[i] = int'(rom[m_pc[i]]);
            if (ph == 3) begin
                m_ret[i] = (m_ret[i] >= 255) ? 255 : m_ret[i] + 1;
                if (i == 0 && m_pc[i] == 15) m_run[i] = 2;
                else begin
                    m_pc[i] = (m_pc[i] + 1) % 16;
`ifdef CPU_CTRL_STEP_EN
                    if (step_mode) m_run[i] = 3;
`endif
                end
            end
            m_cyc[i]++;
        end else begin
`ifdef CPU_CTRL_STEP_EN
            if (step || !step_mode) m_run[i] = 1;
`endif
        end
    endtask

    task automatic chk_dut(input int i, input string tag,
                           input logic [3:0] pc, input logic [7:0] ir,
                           input logic rwe, input logic mwe,
                           input logic [1:0] wb, input logic bsy,
                           input logic hlt, input logic [7:0] ret);
        int  ph, op;
        bit  act;
        act = (m_run[i] == 1);
        ph  = m_cyc[i] % 4;
        op  = m_ir[i] / 64;
        chk({tag, ".pc"}, int'(pc), m_pc[i]);
        chk({tag, ".ir"}, int'(ir), m_ir[i]);
        chk({tag, ".mem_we"}, int'(mwe),
            int'(act && ph == 2 && op == 3 && !reset));
        chk({tag, ".reg_we"}, int'(rwe),
            int'(act && ph == 3 && op != 3 && !reset));
        chk({tag, ".wb_sel"}, int'(wb),
            (act && ph == 3 && op != 3) ? op : 0);
        chk({tag, ".busy"}, int'(bsy), int'(m_run[i] == 1 || m_run[i] == 3));
        chk({tag, ".halted"}, int'(hlt), int'(m_run[i] == 2));
        chk({tag, ".retired"}, int'(ret), m_ret[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
    endtask

    task automatic check();
        @(negedge clk);
        chk_dut(0, "halt", pc_a, ir_a, rwe_a, mwe_a, wb_a, busy_a, halt_a, ret_a);
        chk_dut(1, "wrap", pc_b, ir_b, rwe_b, mwe_b, wb_b, busy_b, halt_b, ret_b);
    endtask

    task automatic cycle();
        tick();
        check();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{instr: 8'h05, exp_reg: 1'b1, exp_mem: 1'b0, exp_wb: 2'b00};
        vecs[1] = '{instr: 8'h46, exp_reg: 1'b1, exp_mem: 1'b0, exp_wb: 2'b01};
        vecs[2] = '{instr: 8'h9B, exp_reg: 1'b1, exp_mem: 1'b0, exp_wb: 2'b10};
        vecs[3] = '{instr: 8'hC3, exp_reg: 1'b0, exp_mem: 1'b1, exp_wb: 2'b00};
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_cyc[i] = 0; m_pc[i] = 0; m_ir[i] = 0; m_ret[i] = 0;
        end

        @(negedge clk);
        do_reset();
        chk("rst.pc", int'(pc_a), 0);
        chk("rst.busy", int'(busy_a), 0);
        chk("rst.ir", int'(ir_a), 0);

        // Single-instruction decode vectors, phase by phase
        for (int v = 0; v < 4; v++) begin
            rom[0] = vecs[v].instr;
            do_reset();
            do_start();
            chk("vec.fetch_rwe", int'(rwe_a), 0);
            cycle();
            chk("vec.ir", int'(ir_a), int'(vecs[v].instr));
            chk("vec.decode_mwe", int'(mwe_a), 0);
            cycle();
            chk("vec.exec_mwe", int'(mwe_a), int'(vecs[v].exp_mem));
            chk("vec.exec_rwe", int'(rwe_a), 0);
            cycle();
            chk("vec.wb_rwe", int'(rwe_a), int'(vecs[v].exp_reg));
            chk("vec.wb_sel", int'(wb_a), int'(vecs[v].exp_wb));
            chk("vec.wb_mwe", int'(mwe_a), 0);
            cycle();
            chk("vec.pc", int'(pc_a), 1);
            chk("vec.retired", int'(ret_a), 1);
        end

        // Reset landing in the EXECUTE cycle of an SW
        rom[0] = 8'hC3;
        do_reset();
        do_start();
        cycle();
        tick();
        #1 reset = 1'b1;
        check();
        chk("abort.mwe", int'(mwe_a), 0);
        cycle();
        chk("abort.pc", int'(pc_a), 0);
        chk("abort.retired", int'(ret_a), 0);
        chk("abort.busy", int'(busy_a), 0);
        reset = 1'b0;

        // Full 16-instruction program: halt vs wrap
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        do_reset();
        do_start();
        for (int c = 0; c < 64; c++) begin
            if (c == 9 || c == 30) start = 1'b1;
            cycle();
            start = 1'b0;
        end
        chk("prog.halted", int'(halt_a), 1);
        chk("prog.pc", int'(pc_a), 15);
        chk("prog.retired", int'(ret_a), 16);
        chk("prog.wrap_pc", int'(pc_b), 0);
        chk("prog.wrap_busy", int'(busy_b), 1);
        chk("prog.wrap_retired", int'(ret_b), 16);
        repeat (3) cycle();
        do_start();
        chk("restart.pc", int'(pc_a), 0);
        chk("restart.retired", int'(ret_a), 0);
        chk("restart.busy", int'(busy_a), 1);

`ifdef CPU_CTRL_STEP_EN
        step_mode = 1'b1;
        do_reset();
        do_start();
        repeat (4) cycle();
        chk("step.pause_pc", int'(pc_a), 1);
        repeat (5) cycle();
        chk("step.hold_pc", int'(pc_a), 1);
        chk("step.hold_busy", int'(busy_a), 1);
        step = 1'b1;
        cycle();
        step = 1'b0;
        repeat (4) cycle();
        chk("step.one_instr", int'(pc_a), 2);
        step_mode = 1'b0;
        repeat (5) cycle();
        chk("step.resume", int'(pc_a), 3);
`endif

        // Random start/reset/ROM traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) rom[$urandom_range(0, 15)] = 8'($urandom);
`ifdef CPU_CTRL_STEP_EN
            if ($urandom_range(0, 63) == 0) step_mode = ~step_mode;
            step = ($urandom_range(0, 5) == 0);
`endif
            cycle();
        end
        start = 1'b0;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Multi-cycle control sequencer for the 8-bit mini CPU. It fetches each instruction from the instruction ROM into an instruction register and steps the register file, ALU and data memory through fixed FETCH/DECODE/EXECUTE/WRITEBACK phases. It drives the PC, the instruction register, the write-back mux select and all write enables. It replaces the one-cycle control always-block, so every write enable is issued in a defined phase rather than in the fetch cycle.

## Interface
- PC_W, 4, PC width; ROM depth 2^PC_W
- LAST_ADDR, 4'hF, address of the final program instruction
- HALT_ON_LAST, 1, 1: halt after retiring LAST_ADDR; 0: PC wraps to 0 and execution continues
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE/HALT and begins at PC 0
- instr  in  8  ROM data, combinational on pc
- pc  out  PC_W  program counter / ROM address
- ir  out  8  latched instruction: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2, [3:0] imm/addr
- reg_write_en  out  1  register file write strobe
- wb_sel  out  2  write-back source: 00 zero-extended imm, 01 ALU result, 10 rs1 + imm
- mem_write_en  out  1  data memory write strobe; address is ir[3:0], data is rs1
- busy  out  1  high in FETCH..WRITEBACK (and PAUSE)
- halted  out  1  high in HALT
- retired  out  8  saturating count of retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT (plus PAUSE when the step feature is compiled in).
- Reset, from any state: state=IDLE, pc=0, ir=8'h00, retired=0, wb_sel=00, all strobes 0, busy=0, halted=0.
- IDLE/HALT with start=1: pc<=0, retired<=0, go to FETCH. start is ignored in all other states.
- FETCH: ir<=instr. Next state is DECODE.
- DECODE: no strobes; register file reads settle on ir rs1/rs2. Next state is EXECUTE.
- EXECUTE: for opcode 11 (SW), mem_write_en=1 for exactly this cycle. Next state is WRITEBACK.
- WRITEBACK: for opcodes 00/01/10, reg_write_en=1 with wb_sel set to 00/01/10 respectively. SW asserts nothing here. retired increments and saturates at 8'hFF.
  - If pc==LAST_ADDR and HALT_ON_LAST=1: go to HALT; pc holds.
  - Otherwise: pc<=pc+1 (modulo 2^PC_W) and go to FETCH.
- Strobes and wb_sel are Moore outputs decoded from state and ir. wb_sel is 00 outside WRITEBACK.
- At most one strobe is high in any cycle. Strobes are never asserted in IDLE, HALT, FETCH or DECODE.
- Reset asserted mid-instruction aborts that instruction. A pending strobe is not issued in the reset cycle.

## Timing
- Each instruction takes exactly 4 cycles. Throughput is 1 instruction per 4 clocks; there is no overlap.
- A start sampled at edge t puts the FSM in FETCH after t. The first ir is valid after t+1. The first write strobe is high in cycle t+3 (SW) or t+4 (register write).
- pc changes only on the WRITEBACK→FETCH edge, the start edge, or reset. ROM data is therefore stable throughout FETCH.
- retired and pc update on the same edge.

## Configuration
- CPU_CTRL_STEP_EN defined: adds ports step_mode (in, 1) and step (in, 1), plus state PAUSE.
  - With step_mode=1, WRITEBACK goes to PAUSE instead of FETCH. The halt-on-last rule still takes precedence.
  - PAUSE holds pc and asserts busy with no strobes. A step pulse moves PAUSE to FETCH.
  - Clearing step_mode while in PAUSE also resumes to FETCH on the next edge.
- CPU_CTRL_STEP_EN undefined: no step ports and no PAUSE state. Behaviour is exactly as described above.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_LI=2'b00, OP_ADD=2'b01, OP_ADDI=2'b10, OP_SW=2'b11
  - wb_sel constants WB_IMM, WB_ALU, WB_ADDI
  - the state enum ctrl_state_t
- One combinational sub-module, cpu_ctrl_decode, maps opcode to {reg_we, mem_we, wb_sel}. The sequencer gates these outputs by phase.

## Test plan
- Reset, then start; ROM[0]=8'h05 (LI r0,5) → ir=8'h05 after FETCH; reg_write_en=1 with wb_sel=00 only in cycle 4; pc goes 0→1 and retired=1.
- ROM[1]=8'hC3 (SW r0→addr 3) → mem_write_en=1 for exactly one cycle, in EXECUTE; reg_write_en stays 0 for the whole instruction.
- 16-instruction program with HALT_ON_LAST=1 → halted=1 after 64 cycles, pc=4'hF, retired=16. With HALT_ON_LAST=0 → pc wraps to 0 and busy stays 1.
- Assert reset during the EXECUTE phase of an SW → no mem_write_en pulse; state=IDLE, pc=0, retired=0 on the next cycle.
- start pulses during busy are ignored: pc and phase sequence are unchanged. A start in HALT restarts at pc=0 with retired=0.
- With CPU_CTRL_STEP_EN and step_mode=1 → FSM sits in PAUSE after each WRITEBACK; each step pulse executes exactly one instruction (4 cycles).
